// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and byte-engine-side signals of the SPI transaction arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/engine view.
interface spi_txn_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] tx_data;
  logic [N_REQ-1:0]   tx_last;
  logic [N_REQ-1:0]   tx_valid;
  logic [N_REQ-1:0]   tx_ready;
  logic [7:0]         rx_data;
  logic [N_REQ-1:0]   rx_valid;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               eng_start;
  logic [7:0]         eng_tx;
  logic               eng_done;
  logic [7:0]         eng_rx;
  logic [N_REQ-1:0]   cs_n;

  modport slave (
    input  req, tx_data, tx_last, tx_valid, eng_done, eng_rx,
    output tx_ready, rx_data, rx_valid, grant, busy, eng_start, eng_tx, cs_n
  );

  modport master (
    output req, tx_data, tx_last, tx_valid, eng_done, eng_rx,
    input  tx_ready, rx_data, rx_valid, grant, busy, eng_start, eng_tx, cs_n
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one SPI byte engine.
// Latency: chip select is asserted 1 cycle after a request. The owner is stalled via tx_ready; there is no preemption.
module spi_txn_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic clk,
  input  logic rst,
  spi_txn_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, GAP} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, owner, winner;
  logic [PW:0]      idx_w;
  logic             found;
  logic [7:0]       cnt;
  logic             last_q;
  logic [7:0]       eng_tx_q, rx_data_q;
  logic             eng_start_q;
  logic [N_REQ-1:0] rx_valid_q;
  logic [N_REQ-1:0] own_oh;
  logic [7:0]       own_dat;
  logic             own_last, own_req, own_vld, hs;

  // Rotating priority: the first requester at or above rr_ptr wins, with wrap-around.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx_w  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(N_REQ)) idx_w = idx_w - (PW+1)'(N_REQ);
      if (!found && bus.req[idx_w[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[PW-1:0];
      end
    end
  end

  always_comb begin
    own_oh   = '0;
    own_dat  = '0;
    own_last = 1'b0;
    own_req  = 1'b0;
    own_vld  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == PW'(i)) begin
        own_oh[i] = 1'b1;
        own_dat   = bus.tx_data[i*8 +: 8];
        own_last  = bus.tx_last[i];
        own_req   = bus.req[i];
        own_vld   = bus.tx_valid[i];
      end
    end
  end

  assign hs = (state == XFER) && own_vld;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A handshake in XFER wins over a dropped request. Once a byte is launched it always completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|bus.req) state_nxt = SETUP;
      SETUP:   if (!own_req) state_nxt = GAP;
               else if (cnt == 8'd0) state_nxt = XFER;
      XFER:    if (hs) state_nxt = WAIT;
               else if (!own_req) state_nxt = GAP;
      WAIT:    if (bus.eng_done) state_nxt = (last_q || !own_req) ? GAP : XFER;
      GAP:     if (cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      eng_tx_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= '0;
      eng_start_q <= 1'b0;
    end else begin
      eng_start_q <= hs;
      rx_valid_q  <= '0;
      if (state == IDLE && found) owner <= winner;
      if (hs) begin
        eng_tx_q <= own_dat;
        last_q   <= own_last;
      end
      if (state == WAIT && bus.eng_done) begin
        rx_data_q  <= bus.eng_rx;
        rx_valid_q <= own_oh;
      end
      if (state_nxt == GAP && state != GAP) begin
        cnt    <= 8'(GAP_CYC - 1);
        rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end else if (state_nxt == SETUP && state == IDLE) begin
        cnt <= 8'(SETUP_CYC - 1);
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    bus.grant     = (state == SETUP || state == XFER || state == WAIT) ? own_oh : '0;
    bus.cs_n      = ~bus.grant;
    bus.tx_ready  = (state == XFER) ? own_oh : '0;
    bus.busy      = (state != IDLE);
    bus.eng_start = eng_start_q;
    bus.eng_tx    = eng_tx_q;
    bus.rx_data   = rx_data_q;
    bus.rx_valid  = rx_valid_q;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one SPI byte engine (2..8).
REQ-002 Parameter: SETUP_CYC, default 2, clk cycles from cs_n low to first byte issue (1..255).
REQ-003 Parameter: GAP_CYC, default 2, clk cycles cs_n held high between transactions (1..255).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  N_REQ  per-requester transaction request; held high for the whole transaction.
REQ-007 tx_data  in  N_REQ*8  per-requester byte to send; requester i uses bits [8i+7:8i].
REQ-008 tx_last  in  N_REQ  marks the byte offered on tx_data as the final byte.
REQ-009 tx_valid  in  N_REQ  per-requester byte valid.
REQ-010 tx_ready  out  N_REQ  per-requester byte accept; only granted bit may be high.
REQ-011 rx_data  out  8  byte received from the engine, shared by all requesters.
REQ-012 rx_valid  out  N_REQ  one-cycle pulse to granted requester, qualifies rx_data.
REQ-013 grant  out  N_REQ  one-hot current owner; zero when no owner.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 eng_start  out  1  one-cycle pulse launching one byte on the SPI engine.
REQ-016 eng_tx  out  8  byte for the engine, stable from eng_start until eng_done.
REQ-017 eng_done  in  1  one-cycle pulse, engine finished the byte.
REQ-018 eng_rx  in  8  received byte, valid with eng_done.
REQ-019 cs_n  out  N_REQ  per-requester active-low chip select; at most one bit low.

Function
REQ-020 FSM states: IDLE, SETUP, XFER, WAIT, GAP.
REQ-021 IDLE: when req != 0, winner = first set req bit scanning upward from rr_ptr with wrap; next cycle grant = onehot(winner), cs_n[winner] = 0, setup counter loaded, state SETUP.
REQ-022 SETUP: hold SETUP_CYC cycles, then XFER.
REQ-023 XFER: tx_ready[w] = 1 combinationally; on tx_valid[w] & tx_ready[w], latch byte to eng_tx and tx_last to last_q, assert eng_start next cycle, enter WAIT.
REQ-024 WAIT: tx_ready = 0; on eng_done, rx_data <= eng_rx and rx_valid[w] pulses the following cycle; then XFER if last_q = 0, else GAP.
REQ-025 Abort: req[w] low in SETUP or XFER (no handshake that cycle) -> GAP next cycle, no eng_start issued.
REQ-026 req[w] low in WAIT is ignored until eng_done; byte completes, rx_valid pulses, then GAP.
REQ-027 GAP: cs_n all high, grant = 0, rr_ptr <= (w+1) mod N_REQ, hold GAP_CYC cycles, then IDLE.
REQ-028 eng_done outside WAIT is ignored; tx_valid on non-granted requesters is ignored and never accepted.
REQ-029 Requests arriving during any non-IDLE state wait; no preemption.
REQ-030 Minimum per-byte throughput: handshake cycle + eng_start cycle + engine time; no extra bubble after eng_done when next byte is already valid.
REQ-031 Counters 8 bits wide; SETUP_CYC/GAP_CYC counts exact (verified by cycle count from cs_n edge).

Reset
REQ-032 On rst: state IDLE, grant = 0, cs_n all 1, tx_ready = 0, rx_valid = 0, eng_start = 0, eng_tx = 0, rx_data = 0, busy = 0, rr_ptr = 0, counters = 0.
REQ-033 rst asserted mid-transaction overrides all states at next edge; cs_n deasserts that edge; pending eng_done afterwards ignored.

Verification
REQ-034 Single: req[1]=1, two bytes 0xA5, 0x3C (last) -> cs_n[1] low 1 cycle after req, first eng_start 3 cycles after cs_n low (SETUP_CYC=2 plus handshake), rx_valid[1] twice with eng_rx values, cs_n[1] high 2 cycles, then IDLE.
REQ-035 Round-robin: req=4'b1111 held, 1-byte transactions -> grant order 0,1,2,3,0.
REQ-036 Abort: req[2] drops in SETUP -> no eng_start, cs_n[2] high next cycle, GAP of 2 cycles.
REQ-037 Drop in WAIT: req[0] falls after eng_start -> eng_done still produces rx_valid[0], then GAP.
REQ-038 Spurious: eng_done in IDLE and tx_valid[3] while grant=0001 -> no output change, tx_ready[3] stays 0.
REQ-039 Reset mid-byte: rst during WAIT -> all outputs at reset values next cycle, later eng_done produces no rx_valid.
